// File: rtl/pattern_frame_sequencer_if.sv
// Host-side sync/mode inputs and per-pixel control outputs of the pattern frame sequencer.
interface pattern_frame_sequencer_if #(
  parameter int COL_W = 8,
  parameter int ROW_W = 8
);
  logic             f_sync;
  logic [2:0]       Mode;
  logic [1:0]       X;
  logic             pix_valid;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             newLine;
  logic             endLine;
  logic             endFrame;
  logic [1:0]       ValSel;
  logic [1:0]       Xmode;
  logic             cb_bit;
  logic [7:0]       ramp_val;
  logic             busy;
  logic [7:0]       frame_cnt;
  logic             overrun;

  modport master (
    output f_sync, Mode, X,
    input  pix_valid, col, row, newLine, endLine, endFrame,
           ValSel, Xmode, cb_bit, ramp_val, busy, frame_cnt, overrun
  );

  modport slave (
    input  f_sync, Mode, X,
    output pix_valid, col, row, newLine, endLine, endFrame,
           ValSel, Xmode, cb_bit, ramp_val, busy, frame_cnt, overrun
  );
endinterface

// File: rtl/pattern_frame_sequencer.sv
// Frame/line raster sequencer: starts a frame on f_sync, walks active pixels and
// horizontal blanking, and produces per-pixel control for the pattern datapath.
module pattern_frame_sequencer #(
  parameter int H_ACTIVE = 8,
  parameter int V_ACTIVE = 4,
  parameter int H_BLANK  = 2,
  parameter int COL_W    = 8,
  parameter int ROW_W    = 8
) (
  input logic clk,
  input logic rst,
  pattern_frame_sequencer_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HBLANK} state_t;

  localparam int BLK_W = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(H_BLANK - 1);

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [7:0]       ramp_q, ramp_d;
  logic [2:0]       mode_q, mode_d;
  logic [1:0]       x_q, x_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             overrun_q, overrun_d;

  logic start_frame;
  logic line_last;
  logic last_row;
  logic blank_done;

  assign start_frame = (state_q == ST_IDLE) && bus.f_sync && (bus.Mode != 3'b000);
  assign line_last   = (col_q == COL_LAST);
  assign last_row    = (row_q == ROW_LAST);
  assign blank_done  = (blk_q == BLK_LAST);

  // State and datapath registers; reset clears everything including the latched mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      ramp_q      <= '0;
      mode_q      <= '0;
      x_q         <= '0;
      blk_q       <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ramp_q      <= ramp_d;
      mode_q      <= mode_d;
      x_q         <= x_d;
      blk_q       <= blk_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  // Raster state transitions: idle -> active line -> blanking -> next line or idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_frame) state_d = ST_ACTIVE;
      ST_ACTIVE: if (line_last) state_d = ST_HBLANK;
      ST_HBLANK: if (blank_done) state_d = last_row ? ST_IDLE : ST_ACTIVE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Counters, ramp accumulator, mode latch, frame counter and sticky overrun flag.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    ramp_d      = ramp_q;
    mode_d      = mode_q;
    x_d         = x_q;
    blk_d       = blk_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q;
    if ((state_q != ST_IDLE) && bus.f_sync) overrun_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start_frame) begin
          mode_d = bus.Mode;
          x_d    = bus.X;
          col_d  = '0;
          row_d  = '0;
          ramp_d = '0;
          blk_d  = '0;
        end
      end
      ST_ACTIVE: begin
        blk_d = '0;
        if (!line_last) col_d = col_q + 1'b1;
        if (mode_q == 3'b111) ramp_d = ramp_q + {6'd0, x_q} + 8'd1;
        if (line_last && last_row) frame_cnt_d = frame_cnt_q + 8'd1;
      end
      ST_HBLANK: begin
        if (blank_done) begin
          blk_d = '0;
          col_d = '0;
          if (last_row) begin
            row_d  = '0;
            ramp_d = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          blk_d = blk_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Per-pixel control outputs decoded from the current state and latched mode.
  always_comb begin
    bus.pix_valid = (state_q == ST_ACTIVE);
    bus.busy      = (state_q != ST_IDLE);
    bus.col       = col_q;
    bus.row       = row_q;
    bus.newLine   = (state_q == ST_ACTIVE) && (col_q == '0);
    bus.endLine   = (state_q == ST_ACTIVE) && line_last;
    bus.endFrame  = (state_q == ST_ACTIVE) && line_last && last_row;
    bus.Xmode     = x_q;
    bus.ramp_val  = ramp_q;
    bus.frame_cnt = frame_cnt_q;
    bus.overrun   = overrun_q;
    bus.ValSel    = 2'b00;
    bus.cb_bit    = 1'b0;
    case (mode_q)
      3'b010:                         bus.ValSel = 2'b01;
      3'b011, 3'b100, 3'b101, 3'b110: bus.ValSel = 2'b10;
      3'b111:                         bus.ValSel = 2'b11;
      default:                        bus.ValSel = 2'b00;
    endcase
    case (mode_q)
      3'b011:  bus.cb_bit = ~(col_q[0] ^ row_q[0]);
      3'b100:  bus.cb_bit = col_q[0] ^ row_q[0];
      3'b101:  bus.cb_bit = ~(col_q[1] ^ row_q[1]);
      3'b110:  bus.cb_bit = col_q[1] ^ row_q[1];
      default: bus.cb_bit = 1'b0;
    endcase
  end

endmodule
